instr_loader: RTL and testbench

- Front-end stage that feeds the trainer CPU's instruction-load path.
- Conditions the raw load pushbutton: 2-FF synchroniser plus debounce.
- Generates the slow CPU step clock and its tick from one divider.
- On each clean press, captures a pseudo-random byte and presents it with a write enable held across exactly one CPU step edge. The CPU therefore sees one instruction write per press, never zero and never several.

---
 rtl/instr_loader_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 53 +++++
 rtl/instr_loader.sv | 123 ++++++++++++
 tb/tb_instr_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader_pkg
// Brief    : Shared types, constants and LFSR step function for instr_loader.
// Revision : 1.0
// ============================================================================
package instr_loader_pkg;

    localparam int DEF_DIV_W = 23;
    localparam int DEF_DEB_W = 16;

    localparam logic [7:0] LFSR_MASK = 8'hB8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        PRESENT = 2'd2,
        HOLD    = 2'd3
    } load_state_t;

    // Galois form: taps are applied after the shift, keyed on the bit shifted out.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        lfsr_next = {1'b0, s[7:1]} ^ (s[0] ? LFSR_MASK : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : 2-FF synchroniser, counter debounce and registered rise pulse.
// Revision : 1.0
// ============================================================================
module btn_debounce #(
    parameter int DEB_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db,
    output logic press
);

    localparam logic [DEB_W-1:0] c_CNT_MAX = {DEB_W{1'b1}};

    logic             r_sync0;
    logic             r_sync1;
    logic [DEB_W-1:0] r_cnt;
    logic             r_db;
    logic             r_press;

    // press is raised on the same edge that btn_db goes high, so it stays a single cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync0 <= btn_raw;
            r_sync1 <= r_sync0;
            r_press <= 1'b0;
            if (r_sync1 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_db    <= r_sync1;
                r_cnt   <= '0;
                r_press <= r_sync1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign btn_db = r_db;
    assign press  = r_press;

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Brief    : Button-driven pseudo-random instruction loader with step clock.
// Revision : 1.0
// ============================================================================
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int         DIV_W     = DEF_DIV_W,
    parameter int         DEB_W     = DEF_DEB_W,
    parameter int         DATA_W    = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_raw,
    output logic              step_clk,
    output logic              step_tick,
    output logic [DATA_W-1:0] instr_data,
    output logic              instr_we,
    output logic              busy,
    output logic [7:0]        load_count
);

    localparam logic [DIV_W-1:0] c_TICK_VAL = {1'b0, {(DIV_W-1){1'b1}}};

    logic [DIV_W-1:0]  r_div;
    logic [7:0]        r_lfsr;
    logic              w_btn_db;
    logic              w_press;
    logic              w_tick;

    load_state_t       r_state;
    load_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic [7:0]        r_count;
    logic [7:0]        w_count_nxt;

    btn_debounce #(
        .DEB_W (DEB_W)
    ) u_btn_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .btn_db  (w_btn_db),
        .press   (w_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_lfsr <= LFSR_SEED;
        end else begin
            r_div  <= r_div + 1'b1;
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_tick = (r_div == c_TICK_VAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_we    <= w_we_nxt;
            r_count <= w_count_nxt;
        end
    end

    // ARM ignores a tick seen on the capture cycle itself: the capture edge moves
    // the FSM into ARM, so only the following tick can end it.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_we_nxt    = r_we;
        w_count_nxt = r_count;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_data_nxt  = r_lfsr;
                    w_we_nxt    = 1'b1;
                    w_state_nxt = ARM;
                end
            end
            ARM: begin
                if (w_tick) begin
                    w_state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                w_we_nxt    = 1'b0;
                w_count_nxt = r_count + 8'd1;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (!w_btn_db) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign step_clk   = r_div[DIV_W-1];
    assign step_tick  = w_tick;
    assign instr_data = r_data;
    assign instr_we   = r_we;
    assign busy       = (r_state != IDLE);
    assign load_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_loader
// Brief    : Randomised self-checking bench for instr_loader, small divider.
// Revision : 1.0
// ============================================================================
module tb_instr_loader;

    localparam int DIV_W = 4;
    localparam int DEB_W = 3;
    localparam int DIVN  = 1 << DIV_W;
    localparam int TICKV = (DIVN / 2) - 1;
    localparam int DEBN  = 1 << DEB_W;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic       step_clk;
    logic       step_tick;
    logic [7:0] instr_data;
    logic       instr_we;
    logic       busy;
    logic [7:0] load_count;

    int n_checks = 0;
    int n_fails  = 0;

    // reference model state, describing outputs after the most recent edge
    int       m_edge;
    int       m_div;
    bit       m_s0, m_s1, m_db, m_press;
    int       m_run;
    bit [7:0] m_lfsr;
    int       m_phase;      // 0 idle, 1 write enabled, 2 waiting for release
    int       m_fall_edge;
    bit [7:0] m_data;
    bit       m_we;
    int       m_count;

    instr_loader #(
        .DIV_W     (DIV_W),
        .DEB_W     (DEB_W),
        .DATA_W    (8),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .step_clk   (step_clk),
        .step_tick  (step_tick),
        .instr_data (instr_data),
        .instr_we   (instr_we),
        .busy       (busy),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, m_edge);
        end
    endtask

    function automatic bit [7:0] lfsr_step(input bit [7:0] s);
        bit [7:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 8'hB8;
        return t;
    endfunction

    task automatic model_update();
        int       o_div;
        bit       o_press, o_db;
        bit [7:0] o_lfsr;
        int       o_phase;
        int       wait_n;
        m_edge++;
        if (rst) begin
            m_div = 0; m_s0 = 0; m_s1 = 0; m_db = 0; m_press = 0; m_run = 0;
            m_lfsr = 8'hA5; m_phase = 0; m_data = 0; m_we = 0; m_count = 0;
            return;
        end
        o_div = m_div; o_press = m_press; o_db = m_db; o_lfsr = m_lfsr; o_phase = m_phase;
        m_div  = (m_div + 1) % DIVN;
        m_lfsr = lfsr_step(m_lfsr);
        // debounced level flips after DEBN consecutive edges of disagreement
        m_press = 0;
        if (m_s1 != m_db) begin
            m_run++;
            if (m_run == DEBN) begin
                m_db = m_s1;
                m_run = 0;
                m_press = m_db;
            end
        end else begin
            m_run = 0;
        end
        m_s1 = m_s0;
        m_s0 = btn_raw;
        case (o_phase)
            0: if (o_press) begin
                m_data = o_lfsr;
                m_we = 1;
                m_phase = 1;
                wait_n = ((TICKV - o_div) % DIVN + DIVN) % DIVN;
                if (wait_n == 0) wait_n = DIVN;
                m_fall_edge = m_edge + wait_n + 1;
            end
            1: if (m_edge == m_fall_edge) begin
                m_we = 0;
                m_count = (m_count + 1) % 256;
                m_phase = 2;
            end
            default: if (!o_db) m_phase = 0;
        endcase
    endtask

    task automatic step_edge();
        @(posedge clk);
        model_update();
        #1;
        check("step_clk",   step_clk,   (m_div >= DIVN / 2));
        check("step_tick",  step_tick,  (m_div == TICKV));
        check("instr_we",   instr_we,   m_we);
        check("busy",       busy,       (m_phase != 0));
        check("load_count", load_count, m_count);
        check("instr_data", instr_data, m_data);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_edge();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_edge();
        check("lfsr_reset", dut.r_lfsr, 8'hA5);
        rst = 1'b0;
    endtask

    initial begin
        int start_edge, rise_edge, fall_edge, cnt0;
        bit seen;
        m_edge = 0;
        rst = 1'b1;
        btn_raw = 1'b0;
        step_edge();
        do_reset();

        // idle: divider only
        run(20);

        // clean press: instr_we rises 11 edges after the raw step
        cnt0 = int'(load_count);
        btn_raw = 1'b1;
        start_edge = m_edge;
        rise_edge = -1;
        for (int i = 0; i < 40; i++) begin
            step_edge();
            if (instr_we && rise_edge < 0) rise_edge = m_edge;
        end
        check("press_latency", rise_edge - start_edge, 11);
        check("clean_one_load", load_count, (cnt0 + 1) % 256);
        btn_raw = 1'b0;
        run(20);

        // bounce train then stable high
        cnt0 = int'(load_count);
        for (int b = 0; b < 4; b++) begin
            btn_raw = ~b[0];
            run(3);
        end
        btn_raw = 1'b1;
        run(45);
        check("bounce_one_load", load_count, (cnt0 + 1) % 256);
        btn_raw = 1'b0;
        run(20);

        // press pulse coincides with step_tick: write enable spans the next tick
        seen = 0;
        for (int i = 0; i < DIVN && !seen; i++) begin
            if (m_div == 13) seen = 1; else step_edge();
        end
        check("align_found", seen, 1'b1);
        btn_raw = 1'b1;
        start_edge = m_edge;
        rise_edge = -1;
        fall_edge = -1;
        for (int i = 0; i < 60; i++) begin
            step_edge();
            if (instr_we && rise_edge < 0) rise_edge = m_edge;
            if (!instr_we && rise_edge >= 0 && fall_edge < 0) fall_edge = m_edge;
        end
        check("coinc_latency", rise_edge - start_edge, 11);
        check("coinc_we_width", fall_edge - rise_edge, 17);
        btn_raw = 1'b0;
        run(20);

        // release during the load and press again: two loads in total
        cnt0 = int'(load_count);
        btn_raw = 1'b1;
        run(13);
        btn_raw = 1'b0;
        run(12);
        btn_raw = 1'b1;
        run(60);
        check("repress_two_loads", load_count, (cnt0 + 2) % 256);
        btn_raw = 1'b0;
        run(20);

        // reset while armed aborts the load
        btn_raw = 1'b1;
        seen = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            step_edge();
            if (instr_we && busy) seen = 1;
        end
        check("arm_reached", seen, 1'b1);
        do_reset();
        check("abort_we", instr_we, 1'b0);
        check("abort_count", load_count, 8'd0);
        run(40);
        btn_raw = 1'b0;
        run(20);

        // random levels and bounce widths
        for (int i = 0; i < 200; i++) begin
            btn_raw = 1'($urandom_range(0, 1));
            run(int'($urandom_range(1, 14)));
        end
        btn_raw = 1'b0;
        run(40);

        // 256 loads wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            btn_raw = 1'b1;
            run(32);
            btn_raw = 1'b0;
            run(14);
            if (i == 254) check("count_255", load_count, 8'd255);
        end
        check("count_wrap", load_count, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
